// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode encodings, controller states
// and the opcode legality check.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NOT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_NOR  = 4'b1010;
  localparam logic [3:0] ALU_SUBU = 4'b1011;
  localparam logic [3:0] ALU_ADDU = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT,
      ALU_SLL, ALU_SRL, ALU_NOR, ALU_SUBU, ALU_ADDU: legal = 1'b1;
      default:                                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant: a lone requester always wins,
// and on a tie the port named by prio wins.
module rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       prio,
  output logic [1:0] grant_onehot,
  output logic       grant_idx
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    grant_onehot = 2'b00;
    grant_idx    = 1'b0;
    case (req_valid)
      2'b01: begin
        grant_onehot = 2'b01;
        grant_idx    = 1'b0;
      end
      2'b10: begin
        grant_onehot = 2'b10;
        grant_idx    = 1'b1;
      end
      2'b11: begin
        grant_onehot = prio ? 2'b10 : 2'b01;
        grant_idx    = prio;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered-output ALU between two requesters: accepts one op at a
// time, drives the ALU for two cycles, and returns the captured result per port.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [3:0]  req_op0,
  input  logic [3:0]  req_op1,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_b1,
  input  logic [4:0]  req_sh0,
  input  logic [4:0]  req_sh1,
  output logic [1:0]  resp_valid,
  input  logic [1:0]  resp_ready,
  output logic [31:0] resp_result,
  output logic        resp_overflow,
  output logic        resp_zero,
  output logic        resp_less,
  output logic        resp_err,
  output logic        busy,
  output logic [3:0]  alu_control,
  output logic [31:0] operand_A,
  output logic [31:0] operand_B,
  output logic [4:0]  shmant,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow,
  input  logic        alu_zero,
  input  logic        alu_less
);

  state_e      state_q, state_d;
  logic        prio_q, prio_d;
  logic        grant_q, grant_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [4:0]  sh_q, sh_d;
  logic [1:0]  resp_valid_q, resp_valid_d;
  logic [31:0] result_q, result_d;
  logic        ovf_q, ovf_d, zero_q, zero_d, less_q, less_d, err_q, err_d;

  logic [1:0]  arb_onehot;
  logic        arb_idx;
  logic        alu_drive;

  rr_arb2 u_rr_arb2 (
    .req_valid    (req_valid),
    .prio         (prio_q),
    .grant_onehot (arb_onehot),
    .grant_idx    (arb_idx)
  );

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    grant_d      = grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    sh_d         = sh_q;
    resp_valid_d = resp_valid_q;
    result_d     = result_q;
    ovf_d        = ovf_q;
    zero_d       = zero_q;
    less_d       = less_q;
    err_d        = err_q;
    req_ready    = 2'b00;

    case (state_q)
      ST_IDLE: begin
        req_ready = arb_onehot;
        if (arb_onehot != 2'b00) begin
          grant_d = arb_idx;
          op_d    = arb_idx ? req_op1 : req_op0;
          a_d     = arb_idx ? req_a1  : req_a0;
          b_d     = arb_idx ? req_b1  : req_b0;
          sh_d    = arb_idx ? req_sh1 : req_sh0;
          if (is_legal_op(op_d)) begin
            state_d = ST_ISSUE;
          end else begin
            // Rejected opcodes never reach the ALU; respond immediately.
            resp_valid_d = arb_onehot;
            result_d     = '0;
            ovf_d        = 1'b0;
            zero_d       = 1'b0;
            less_d       = 1'b0;
            err_d        = 1'b1;
            state_d      = ST_RESP;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        resp_valid_d = grant_q ? 2'b10 : 2'b01;
        result_d     = alu_result;
        ovf_d        = alu_overflow;
        zero_d       = alu_zero;
        less_d       = alu_less;
        err_d        = 1'b0;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready[grant_q]) begin
          resp_valid_d = 2'b00;
          prio_d       = ~grant_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the latched request and response registers are reset too, so nothing stale can leak onto the ALU or response ports.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      prio_q       <= 1'b0;
      grant_q      <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sh_q         <= '0;
      resp_valid_q <= 2'b00;
      result_q     <= '0;
      ovf_q        <= 1'b0;
      zero_q       <= 1'b0;
      less_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from the same pre-edge values.
      state_q      <= state_d;
      prio_q       <= prio_d;
      grant_q      <= grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sh_q         <= sh_d;
      resp_valid_q <= resp_valid_d;
      result_q     <= result_d;
      ovf_q        <= ovf_d;
      zero_q       <= zero_d;
      less_q       <= less_d;
      err_q        <= err_d;
    end
  end

  // The ALU samples in ISSUE; WAIT keeps the drive stable while its output settles.
  assign alu_drive     = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign alu_control   = alu_drive ? op_q : 4'b0000;
  assign operand_A     = alu_drive ? a_q  : '0;
  assign operand_B     = alu_drive ? b_q  : '0;
  assign shmant        = alu_drive ? sh_q : '0;

  assign busy          = (state_q != ST_IDLE);
  assign resp_valid    = resp_valid_q;
  assign resp_result   = result_q;
  assign resp_overflow = ovf_q;
  assign resp_zero     = zero_q;
  assign resp_less     = less_q;
  assign resp_err      = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a stand-in registered ALU, a table of single-port
// operations, and hand sequences for arbitration, back-pressure and reset.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid, req_ready;
  logic [3:0]  req_op0, req_op1;
  logic [31:0] req_a0, req_a1, req_b0, req_b1;
  logic [4:0]  req_sh0, req_sh1;
  logic [1:0]  resp_valid, resp_ready;
  logic [31:0] resp_result;
  logic        resp_overflow, resp_zero, resp_less, resp_err, busy;
  logic [3:0]  alu_control;
  logic [31:0] operand_A, operand_B;
  logic [4:0]  shmant;
  logic [31:0] alu_result;
  logic        alu_overflow, alu_zero, alu_less;

  int total = 0;
  int bad   = 0;

  alu_arbiter dut (
    .clk (clk), .reset (reset),
    .req_valid (req_valid), .req_ready (req_ready),
    .req_op0 (req_op0), .req_op1 (req_op1),
    .req_a0 (req_a0), .req_a1 (req_a1), .req_b0 (req_b0), .req_b1 (req_b1),
    .req_sh0 (req_sh0), .req_sh1 (req_sh1),
    .resp_valid (resp_valid), .resp_ready (resp_ready),
    .resp_result (resp_result), .resp_overflow (resp_overflow),
    .resp_zero (resp_zero), .resp_less (resp_less), .resp_err (resp_err),
    .busy (busy),
    .alu_control (alu_control), .operand_A (operand_A), .operand_B (operand_B),
    .shmant (shmant),
    .alu_result (alu_result), .alu_overflow (alu_overflow),
    .alu_zero (alu_zero), .alu_less (alu_less)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in ALU: one registered stage, less = result sign, reset with the arbiter.
  logic [31:0] m_r;
  logic        m_ovf, m_act;
  always_comb begin
    m_r   = '0;
    m_ovf = 1'b0;
    m_act = 1'b1;
    case (alu_control)
      ALU_ADD: begin
        m_r   = operand_A + operand_B;
        m_ovf = (operand_A[31] == operand_B[31]) && (m_r[31] != operand_A[31]);
      end
      ALU_SUB: begin
        m_r   = operand_A - operand_B;
        m_ovf = (operand_A[31] != operand_B[31]) && (m_r[31] != operand_A[31]);
      end
      ALU_AND:  m_r = operand_A & operand_B;
      ALU_OR:   m_r = operand_A | operand_B;
      ALU_XOR:  m_r = operand_A ^ operand_B;
      ALU_NOT:  m_r = ~operand_A;
      ALU_SLL:  m_r = operand_A << shmant;
      ALU_SRL:  m_r = operand_A >> shmant;
      ALU_NOR:  m_r = ~(operand_A | operand_B);
      ALU_SUBU: m_r = operand_A - operand_B;
      ALU_ADDU: m_r = operand_A + operand_B;
      default:  m_act = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_result   <= '0;
      alu_overflow <= 1'b0;
      alu_zero     <= 1'b0;
      alu_less     <= 1'b0;
    end else begin
      alu_result   <= m_r;
      alu_overflow <= m_ovf;
      alu_zero     <= m_act && (m_r == 32'd0);
      alu_less     <= m_r[31];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_port(input int p, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh);
    if (p == 1) begin
      req_op1 = op; req_a1 = a; req_b1 = b; req_sh1 = sh;
    end else begin
      req_op0 = op; req_a0 = a; req_b0 = b; req_sh0 = sh;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"},        32'(busy),          32'd0);
    check({tag, " resp_valid"},  32'(resp_valid),    32'd0);
    check({tag, " req_ready"},   32'(req_ready),     32'd0);
    check({tag, " alu_control"}, 32'(alu_control),   32'd0);
    check({tag, " operand_A"},   operand_A,          32'd0);
    check({tag, " operand_B"},   operand_B,          32'd0);
    check({tag, " shmant"},      32'(shmant),        32'd0);
    check({tag, " resp_result"}, resp_result,        32'd0);
    check({tag, " flags"},
          32'({resp_err, resp_overflow, resp_zero, resp_less}), 32'd0);
  endtask

  // Called in the low phase of the handshake cycle with the request already driven.
  // exp_fl = {err, overflow, zero, less}.
  task automatic txn(input string tag, input int p, input logic [3:0] op,
                     input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                     input logic [31:0] exp_res, input logic [3:0] exp_fl,
                     input bit drop, input int hold);
    logic [1:0] oh;
    bit legal;
    oh    = (p == 1) ? 2'b10 : 2'b01;
    legal = !exp_fl[3];
    #1;
    check({tag, " req_ready"}, 32'(req_ready), 32'(oh));
    @(posedge clk);
    @(negedge clk);
    if (drop) req_valid[p] = 1'b0;
    #1;
    check({tag, " busy c1"}, 32'(busy), 32'd1);
    if (legal) begin
      check({tag, " alu_control c1"}, 32'(alu_control), 32'(op));
      check({tag, " resp_valid c1"},  32'(resp_valid),  32'd0);
      @(negedge clk);
      #1;
      check({tag, " alu_control c2"}, 32'(alu_control), 32'(op));
      check({tag, " operand_A c2"},   operand_A,         a);
      check({tag, " operand_B c2"},   operand_B,         b);
      check({tag, " shmant c2"},      32'(shmant),       32'(sh));
      check({tag, " resp_valid c2"},  32'(resp_valid),   32'd0);
      @(negedge clk);
      #1;
    end
    check({tag, " resp_valid"},  32'(resp_valid),    32'(oh));
    check({tag, " resp_result"}, resp_result,        exp_res);
    check({tag, " resp_flags"},
          32'({resp_err, resp_overflow, resp_zero, resp_less}), 32'(exp_fl));
    check({tag, " req_ready busy"}, 32'(req_ready),   32'd0);
    check({tag, " alu_control resp"}, 32'(alu_control), 32'd0);
    for (int i = 0; i < hold; i++) begin
      resp_ready = ~oh;
      @(negedge clk);
      #1;
      check({tag, " hold resp_valid"},  32'(resp_valid), 32'(oh));
      check({tag, " hold resp_result"}, resp_result,     exp_res);
      check({tag, " hold flags"},
            32'({resp_err, resp_overflow, resp_zero, resp_less}), 32'(exp_fl));
      check({tag, " hold req_ready"},   32'(req_ready),  32'd0);
    end
    resp_ready = oh;
    @(negedge clk);
    resp_ready = 2'b00;
    #1;
    check({tag, " resp_valid after accept"}, 32'(resp_valid), 32'd0);
    check({tag, " busy after accept"},       32'(busy),       32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset      = 1'b1;
    req_valid  = 2'b00;
    resp_ready = 2'b00;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    int          port;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] exp_res;
    logic [3:0]  exp_fl;
  } vec_t;

  vec_t vecs[16];

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    req_valid  = 2'b00;
    resp_ready = 2'b00;
    set_port(0, 4'd0, 32'd0, 32'd0, 5'd0);
    set_port(1, 4'd0, 32'd0, 32'd0, 5'd0);

    vecs[0]  = '{0, ALU_ADD,  32'd5,          32'd7,          5'd0,  32'd12,         4'b0000};
    vecs[1]  = '{1, ALU_SUB,  32'd9,          32'd4,          5'd0,  32'd5,          4'b0000};
    vecs[2]  = '{0, ALU_AND,  32'h0000_00F0,  32'h0000_003C,  5'd0,  32'h0000_0030,  4'b0000};
    vecs[3]  = '{0, ALU_SLL,  32'd1,          32'd0,          5'd31, 32'h8000_0000,  4'b0001};
    vecs[4]  = '{1, ALU_SRL,  32'h8000_0000,  32'd0,          5'd4,  32'h0800_0000,  4'b0000};
    vecs[5]  = '{0, ALU_XOR,  32'h0000_AAAA,  32'h0000_AAAA,  5'd0,  32'd0,          4'b0010};
    vecs[6]  = '{1, ALU_ADD,  32'h7FFF_FFFF,  32'd1,          5'd0,  32'h8000_0000,  4'b0101};
    vecs[7]  = '{0, ALU_NOR,  32'd0,          32'd0,          5'd0,  32'hFFFF_FFFF,  4'b0001};
    vecs[8]  = '{1, 4'b0000,  32'h0000_1234,  32'd5,          5'd0,  32'd0,          4'b1000};
    vecs[9]  = '{0, 4'b1111,  32'd3,          32'd3,          5'd0,  32'd0,          4'b1000};
    vecs[10] = '{0, ALU_OR,   32'h0000_0F00,  32'h0000_00F0,  5'd0,  32'h0000_0FF0,  4'b0000};
    vecs[11] = '{1, ALU_NOT,  32'd0,          32'd0,          5'd0,  32'hFFFF_FFFF,  4'b0001};
    vecs[12] = '{0, ALU_SUBU, 32'd3,          32'd5,          5'd0,  32'hFFFF_FFFE,  4'b0001};
    vecs[13] = '{1, ALU_ADDU, 32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0,          4'b0010};
    vecs[14] = '{1, 4'b1101,  32'd7,          32'd1,          5'd0,  32'd0,          4'b1000};
    vecs[15] = '{0, 4'b0001,  32'd7,          32'd1,          5'd0,  32'd0,          4'b1000};

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs("reset");

    foreach (vecs[i]) begin
      set_port(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh);
      req_valid = (vecs[i].port == 1) ? 2'b10 : 2'b01;
      txn($sformatf("vec%0d", i), vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b,
          vecs[i].sh, vecs[i].exp_res, vecs[i].exp_fl, 1'b1, 0);
    end

    // Simultaneous requests from reset: port 0, then port 1, then port 0 again,
    // the last one with the response held back for 5 cycles.
    pulse_reset();
    set_port(0, ALU_SUB, 32'd9,   32'd4,   5'd0);
    set_port(1, ALU_AND, 32'hF0,  32'h3C,  5'd0);
    req_valid = 2'b11;
    txn("rr first",  0, ALU_SUB, 32'd9,  32'd4,  5'd0, 32'd5,  4'b0000, 1'b0, 0);
    txn("rr second", 1, ALU_AND, 32'hF0, 32'h3C, 5'd0, 32'h30, 4'b0000, 1'b0, 0);
    txn("rr third",  0, ALU_SUB, 32'd9,  32'd4,  5'd0, 32'd5,  4'b0000, 1'b0, 5);
    req_valid = 2'b00;

    // Reset landing in WAIT drops the operation; port 1 is served right after.
    set_port(0, ALU_ADD, 32'd5, 32'd7, 5'd0);
    req_valid = 2'b01;
    #1;
    check("rstwait req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    check("rstwait alu_control in WAIT", 32'(alu_control), 32'(ALU_ADD));
    reset = 1'b1;
    #1;
    check_reset_outputs("rstwait");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rstwait no response", 32'(resp_valid), 32'd0);
    set_port(1, ALU_ADD, 32'd2, 32'd3, 5'd0);
    req_valid = 2'b10;
    txn("after reset", 1, ALU_ADD, 32'd2, 32'd3, 5'd0, 32'd5, 4'b0000, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
